// File: rtl/wb_stage_if.sv
// Writeback stage bus: MEM-stage payload and LSU response in, regfile write / forward / status out.
interface wb_stage_if #(
   parameter int unsigned CNT_W = 64
);
   logic             mem_valid;
   logic             mem_reg_wr;
   logic [4:0]       mem_rd;
   logic [1:0]       mem_wb_sel;
   logic [31:0]      mem_alu_res;
   logic [31:0]      mem_pc4;
   logic [2:0]       mem_funct3;
   logic [1:0]       mem_addr_lo;
   logic             lsu_rvalid;
   logic [31:0]      lsu_rdata;
   logic             lsu_err;
   logic             wb_stall;
   logic             rf_wr_en;
   logic [4:0]       rf_wr_addr;
   logic [31:0]      rf_wr_data;
   logic             fwd_valid;
   logic [4:0]       fwd_rd;
   logic [31:0]      fwd_data;
   logic             load_err;
   logic [CNT_W-1:0] instret;

   // Upstream/LSU side (drives the stage)
   modport master (
      output mem_valid, mem_reg_wr, mem_rd, mem_wb_sel, mem_alu_res, mem_pc4,
             mem_funct3, mem_addr_lo, lsu_rvalid, lsu_rdata, lsu_err,
      input  wb_stall, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_valid, fwd_rd,
             fwd_data, load_err, instret
   );

   // Writeback stage side
   modport slave (
      input  mem_valid, mem_reg_wr, mem_rd, mem_wb_sel, mem_alu_res, mem_pc4,
             mem_funct3, mem_addr_lo, lsu_rvalid, lsu_rdata, lsu_err,
      output wb_stall, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_valid, fwd_rd,
             fwd_data, load_err, instret
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, result select, load alignment, LSU wait with timeout, retire count.
module wb_stage #(
   parameter int unsigned LOAD_TIMEOUT = 64,
   parameter int unsigned CNT_W        = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   wb_stage_if.slave  bus
);
   localparam int unsigned TW = $clog2(LOAD_TIMEOUT + 1);

   typedef enum logic [1:0] {EMPTY = 2'd0, HOLD = 2'd1, LD_WAIT = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic             reg_wr_q, reg_wr_d;
   logic [4:0]       rd_q, rd_d;
   logic [1:0]       wb_sel_q, wb_sel_d;
   logic [31:0]      alu_q, alu_d;
   logic [31:0]      pc4_q, pc4_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [1:0]       addr_lo_q, addr_lo_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic             stall, retire, ld_err, wr_en;
   logic [31:0]      wr_data, ld_data;
   logic [7:0]       ld_b;
   logic [15:0]      ld_h;

   // State and MEM/WB register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         tcnt_q    <= '0;
         reg_wr_q  <= 1'b0;
         rd_q      <= '0;
         wb_sel_q  <= '0;
         alu_q     <= '0;
         pc4_q     <= '0;
         funct3_q  <= '0;
         addr_lo_q <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         reg_wr_q  <= reg_wr_d;
         rd_q      <= rd_d;
         wb_sel_q  <= wb_sel_d;
         alu_q     <= alu_d;
         pc4_q     <= pc4_d;
         funct3_q  <= funct3_d;
         addr_lo_q <= addr_lo_d;
         instret_q <= instret_d;
      end
   end

   // Load data alignment and extension; addr_lo[0] does not affect halfwords
   always_comb begin
      ld_b = bus.lsu_rdata[{addr_lo_q, 3'b000} +: 8];
      ld_h = bus.lsu_rdata[{addr_lo_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
         3'b100:  ld_data = {24'd0, ld_b};
         3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
         3'b101:  ld_data = {16'd0, ld_h};
         default: ld_data = bus.lsu_rdata;
      endcase
   end

   // Next state, stall/retire decisions and write-port outputs
   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      reg_wr_d  = reg_wr_q;
      rd_d      = rd_q;
      wb_sel_d  = wb_sel_q;
      alu_d     = alu_q;
      pc4_d     = pc4_q;
      funct3_d  = funct3_q;
      addr_lo_d = addr_lo_q;
      instret_d = instret_q;
      stall     = 1'b0;
      retire    = 1'b0;
      ld_err    = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;

      case (state_q)
         HOLD: retire = 1'b1;
         LD_WAIT: begin
            if (bus.lsu_rvalid) begin
               if (bus.lsu_err) ld_err = 1'b1;
               else             retire = 1'b1;
            end else if (tcnt_q == TW'(LOAD_TIMEOUT - 1)) begin
               ld_err = 1'b1;
            end else begin
               stall  = 1'b1;
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: ;
      endcase

      if (retire) instret_d = instret_q + CNT_W'(1);

      wr_en = retire && reg_wr_q && (rd_q != 5'd0);
      if (wr_en) begin
         if (state_q == LD_WAIT)    wr_data = ld_data;
         else if (wb_sel_q == 2'b10) wr_data = pc4_q;
         else                        wr_data = alu_q;
      end

      // Capture the next instruction whenever not stalled, including the load-completion cycle
      if (!stall) begin
         reg_wr_d  = bus.mem_reg_wr;
         rd_d      = bus.mem_rd;
         wb_sel_d  = bus.mem_wb_sel;
         alu_d     = bus.mem_alu_res;
         pc4_d     = bus.mem_pc4;
         funct3_d  = bus.mem_funct3;
         addr_lo_d = bus.mem_addr_lo;
         tcnt_d    = '0;
         if (!bus.mem_valid)               state_d = EMPTY;
         else if (bus.mem_wb_sel == 2'b01) state_d = LD_WAIT;
         else                              state_d = HOLD;
      end
   end

   assign bus.wb_stall   = stall;
   assign bus.rf_wr_en   = wr_en;
   assign bus.rf_wr_addr = wr_en ? rd_q : 5'd0;
   assign bus.rf_wr_data = wr_data;
   assign bus.fwd_valid  = wr_en;
   assign bus.fwd_rd     = wr_en ? rd_q : 5'd0;
   assign bus.fwd_data   = wr_data;
   assign bus.load_err   = ld_err;
   assign bus.instret    = instret_q;
endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage with a short load timeout.
module tb_wb_stage;
   localparam int unsigned CNT_W = 64;

   logic clk;
   logic rst_n;
   int   nvec;
   int   nerr;

   wb_stage_if #(.CNT_W(CNT_W)) bus ();

   wb_stage #(.LOAD_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next posedge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.mem_valid   = 1'b0;
      bus.mem_reg_wr  = 1'b0;
      bus.mem_rd      = '0;
      bus.mem_wb_sel  = '0;
      bus.mem_alu_res = '0;
      bus.mem_pc4     = '0;
      bus.mem_funct3  = '0;
      bus.mem_addr_lo = '0;
      bus.lsu_rvalid  = 1'b0;
      bus.lsu_rdata   = '0;
      bus.lsu_err     = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [2:0] f3, input logic [1:0] alo);
      bus.mem_valid   = 1'b1;
      bus.mem_reg_wr  = 1'b1;
      bus.mem_rd      = rd;
      bus.mem_wb_sel  = sel;
      bus.mem_alu_res = alu;
      bus.mem_pc4     = pc4;
      bus.mem_funct3  = f3;
      bus.mem_addr_lo = alo;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".wr_en"},  64'(bus.rf_wr_en),   64'd0);
      chk({tag, ".fwd_v"},  64'(bus.fwd_valid),  64'd0);
      chk({tag, ".data"},   64'(bus.rf_wr_data), 64'd0);
      chk({tag, ".ld_err"}, 64'(bus.load_err),   64'd0);
      chk({tag, ".stall"},  64'(bus.wb_stall),   64'd0);
   endtask

   task automatic chk_write(input string tag, input logic [4:0] rd, input logic [31:0] d);
      chk({tag, ".wr_en"}, 64'(bus.rf_wr_en),   64'd1);
      chk({tag, ".addr"},  64'(bus.rf_wr_addr), 64'(rd));
      chk({tag, ".data"},  64'(bus.rf_wr_data), 64'(d));
      chk({tag, ".fwd_v"}, 64'(bus.fwd_valid),  64'd1);
      chk({tag, ".fwd_rd"},64'(bus.fwd_rd),     64'(rd));
      chk({tag, ".fwd_d"}, 64'(bus.fwd_data),   64'(d));
      chk({tag, ".stall"}, 64'(bus.wb_stall),   64'd0);
   endtask

   initial begin
      nvec  = 0;
      nerr  = 0;
      rst_n = 1'b0;
      idle_in();
      #12;
      chk_quiet("reset");
      chk("reset.instret", bus.instret, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU write rd=5
      step();
      issue(5'd5, 2'b00, 32'h1234, 32'h0, 3'b000, 2'b00);
      #1 chk("alu.pre_stall", 64'(bus.wb_stall), 64'd0);
      step();
      idle_in();
      #1 chk_write("alu", 5'd5, 32'h1234);
      chk("alu.instret_same", bus.instret, 64'd0);
      step();
      #1 chk("alu.instret", bus.instret, 64'd1);
      chk("alu.after_wr", 64'(bus.rf_wr_en), 64'd0);

      // lb addr_lo=3, rvalid after three wait cycles
      issue(5'd7, 2'b01, 32'h0, 32'h0, 3'b000, 2'd3);
      step();
      idle_in();
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("lb.stall%0d", i), 64'(bus.wb_stall), 64'd1);
         chk($sformatf("lb.nowr%0d", i), 64'(bus.rf_wr_en), 64'd0);
         step();
      end
      bus.lsu_rvalid = 1'b1;
      bus.lsu_rdata  = 32'h80FF_0000;
      #1 chk_write("lb", 5'd7, 32'hFFFF_FF80);
      step();
      idle_in();
      #1 chk("lb.instret", bus.instret, 64'd2);

      // lhu addr_lo=2, rvalid in capture cycle, jal rd=0 captured back-to-back
      issue(5'd8, 2'b01, 32'h0, 32'h0, 3'b101, 2'd2);
      step();
      issue(5'd0, 2'b10, 32'hDEAD, 32'h104, 3'b000, 2'd0);
      bus.lsu_rvalid = 1'b1;
      bus.lsu_rdata  = 32'hBEEF_1234;
      #1 chk_write("lhu", 5'd8, 32'h0000_BEEF);
      step();
      idle_in();
      #1 chk_quiet("jal_x0");
      chk("jal.instret_same", bus.instret, 64'd3);
      step();
      #1 chk("jal.instret", bus.instret, 64'd4);

      // Timeout: three stall cycles then error pulse, no write
      issue(5'd9, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
      step();
      idle_in();
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("to.stall%0d", i), 64'(bus.wb_stall), 64'd1);
         step();
      end
      #1 chk("to.stall_rel", 64'(bus.wb_stall), 64'd0);
      chk("to.ld_err", 64'(bus.load_err), 64'd1);
      chk("to.nowr", 64'(bus.rf_wr_en), 64'd0);
      step();
      bus.lsu_rvalid = 1'b1;
      bus.lsu_rdata  = 32'h5555_5555;
      #1 chk_quiet("to.late_rvalid");
      step();
      idle_in();
      #1 chk("to.instret", bus.instret, 64'd4);

      // Bus error on first LD_WAIT cycle
      issue(5'd10, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
      step();
      idle_in();
      bus.lsu_rvalid = 1'b1;
      bus.lsu_err    = 1'b1;
      bus.lsu_rdata  = 32'hAAAA_AAAA;
      #1 chk("err.ld_err", 64'(bus.load_err), 64'd1);
      chk("err.nowr", 64'(bus.rf_wr_en), 64'd0);
      chk("err.stall", 64'(bus.wb_stall), 64'd0);
      step();
      idle_in();
      #1 chk("err.pulse_end", 64'(bus.load_err), 64'd0);
      chk("err.instret", bus.instret, 64'd4);

      // lh with addr_lo=1 selects the low half, sign-extended
      issue(5'd12, 2'b01, 32'h0, 32'h0, 3'b001, 2'd1);
      step();
      idle_in();
      bus.lsu_rvalid = 1'b1;
      bus.lsu_rdata  = 32'h1234_8001;
      #1 chk_write("lh", 5'd12, 32'hFFFF_8001);
      step();
      idle_in();

      // Word load with reserved funct3=110, then reg_wr=0 ALU still retires
      issue(5'd13, 2'b01, 32'h0, 32'h0, 3'b110, 2'd3);
      step();
      issue(5'd14, 2'b11, 32'h0BAD_F00D, 32'h0, 3'b000, 2'd0);
      bus.mem_reg_wr = 1'b0;
      bus.lsu_rvalid = 1'b1;
      bus.lsu_rdata  = 32'hCAFE_0001;
      #1 chk_write("lw", 5'd13, 32'hCAFE_0001);
      step();
      idle_in();
      #1 chk_quiet("nowr_alu");
      step();
      #1 chk("nowr.instret", bus.instret, 64'd7);

      // Reserved wb_sel=11 behaves as ALU
      issue(5'd15, 2'b11, 32'h0000_7777, 32'h0000_0999, 3'b000, 2'd0);
      step();
      idle_in();
      #1 chk_write("sel11", 5'd15, 32'h0000_7777);
      step();

      // Reset asserted mid-load abandons the load
      issue(5'd11, 2'b01, 32'h0, 32'h0, 3'b010, 2'd0);
      step();
      idle_in();
      #1 chk("rst.stall_before", 64'(bus.wb_stall), 64'd1);
      rst_n = 1'b0;
      #1 chk_quiet("rst.mid");
      chk("rst.instret", bus.instret, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      bus.lsu_rvalid = 1'b1;
      bus.lsu_rdata  = 32'h1111_2222;
      #1 chk_quiet("rst.late_rvalid");
      step();
      idle_in();
      #1 chk("rst.instret_after", bus.instret, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   // Global time bound
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
